// File: rtl/adc_avg_pkg.sv
// adc_avg_pkg: shared types and constants for the ADC result averager
package adc_avg_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, PUSH} state_t;
  localparam int DATA_W_DEF = 10;
  localparam int ACC_W = DATA_W_DEF + 3;
  localparam int AVG_LOG2_MAX = 3;
endpackage

// File: rtl/adc_res_fifo.sv
// adc_res_fifo: show-ahead sync FIFO (push/push_data/pop in, head/full/empty/count out); push while full is accepted only alongside a pop
module adc_res_fifo #(
  parameter int W = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clkin,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clkin or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clkin)
    if (do_push) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/adc_result_avg.sv
// adc_result_avg: sync adc_done, average 1/2/4/8 results into a show-ahead FIFO with sticky overflow; ADC_AVG_ROUND_EN selects round-half-up
module adc_result_avg
  import adc_avg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clkin,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          adc_done,
  input  logic [DATA_W-1:0]             result,
  input  logic [1:0]                    avg_sel,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_ovf
);
  localparam int AW = DATA_W + AVG_LOG2_MAX;
  logic [SYNC_STAGES:0] sync;
  logic take, start, push, pop, full, empty;
  state_t state;
  logic [AW-1:0] acc;
  logic [AVG_LOG2_MAX:0] cnt;
  logic [1:0] n_log2;
  logic [DATA_W-1:0] avg;
  always_ff @(posedge clkin or posedge rst)
    if (rst) begin
      sync <= '0;
      take <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-1:0], adc_done};
      take <= sync[SYNC_STAGES-1] & ~sync[SYNC_STAGES];
    end
`ifdef ADC_AVG_ROUND_EN
  logic [AW:0] rnd;
  assign rnd = ({1'b0, acc} + (((AW+1)'(1) << n_log2) >> 1)) >> n_log2;
  assign avg = |rnd[AW:DATA_W] ? '1 : rnd[DATA_W-1:0];
`else
  logic [AW-1:0] shifted;
  assign shifted = acc >> n_log2;
  assign avg = shifted[DATA_W-1:0];
`endif
  assign start = enable & take & (state != ACCUM);
  assign push = state == PUSH;
  assign pop = out_valid & out_ready;
  assign out_valid = ~empty;
  always_ff @(posedge clkin or posedge rst)
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      n_log2 <= '0;
    end else if (start) begin
      n_log2 <= avg_sel;
      acc <= AW'(result);
      cnt <= (AVG_LOG2_MAX+1)'(1);
      state <= avg_sel == 2'd0 ? PUSH : ACCUM;
    end else if (state == PUSH || (state == ACCUM && !enable)) begin
      acc <= '0;
      cnt <= '0;
      state <= IDLE;
    end else if (state == ACCUM && take) begin
      acc <= acc + AW'(result);
      cnt <= cnt + (AVG_LOG2_MAX+1)'(1);
      if ((cnt + (AVG_LOG2_MAX+1)'(1)) == ((AVG_LOG2_MAX+1)'(1) << n_log2)) state <= PUSH;
    end
  always_ff @(posedge clkin or posedge rst)
    if (rst) overflow <= 1'b0;
    else if (push & full & ~pop) overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  adc_res_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clkin(clkin),
    .rst(rst),
    .push(push),
    .push_data(avg),
    .pop(pop),
    .head(out_data),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_adc_result_avg.sv
// tb_adc_result_avg: table vectors, corner sequences and random blocks against an arithmetic model
module tb_adc_result_avg;
  localparam int SYNC_STAGES = 2;
  logic clkin = 0, rst = 1, enable = 1, adc_done = 0, out_ready = 0, clr_ovf = 0;
  logic [9:0] result = 0, out_data;
  logic [1:0] avg_sel = 0;
  logic out_valid, overflow;
  logic [2:0] fifo_count;
  int checks = 0, errors = 0;
  int rq[$];
  bit mon_en = 0;
  typedef struct {
    int sel;
    int s[8];
    int et;
    int er;
  } vec_t;
  vec_t tbl[6];

  adc_result_avg #(.DATA_W(10), .FIFO_DEPTH(4), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clkin(clkin), .rst(rst), .enable(enable), .adc_done(adc_done), .result(result),
    .avg_sel(avg_sel), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clkin = ~clkin;

  function automatic int avg_of(int sum, int sel);
`ifdef ADC_AVG_ROUND_EN
    int r = (sum + ((1 << sel) >> 1)) >> sel;
    return r > 1023 ? 1023 : r;
`else
    return (sum >> sel) & 1023;
`endif
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic conv(input int v);
    @(negedge clkin);
    result = 10'(v);
    adc_done = 1;
    @(negedge clkin);
    adc_done = 0;
    repeat (4) @(negedge clkin);
  endtask

  task automatic pop1();
    @(negedge clkin);
    out_ready = 1;
    @(negedge clkin);
    out_ready = 0;
  endtask

  task automatic wait_valid(string name);
    int n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clkin);
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got out_valid=0 expected 1", name);
    end
  endtask

  initial begin
    forever begin
      @(negedge clkin);
      if (mon_en) begin
        out_ready = ($urandom_range(3) != 0);
        if (out_valid && out_ready) begin
          if (rq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rand_extra: got %0d expected no output", out_data);
          end else check("rand_out", int'(out_data), rq.pop_front());
        end
      end
    end
  end

  initial begin
    int n, sum, sel, ns;
    int exp_ovf[4];
    tbl[0] = '{0, '{700, 0, 0, 0, 0, 0, 0, 0}, 700, 700};
    tbl[1] = '{2, '{100, 101, 102, 103, 0, 0, 0, 0}, 101, 102};
    tbl[2] = '{3, '{1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023}, 1023, 1023};
    tbl[3] = '{1, '{3, 4, 0, 0, 0, 0, 0, 0}, 3, 4};
    tbl[4] = '{2, '{0, 0, 0, 1, 0, 0, 0, 0}, 0, 0};
    tbl[5] = '{3, '{1, 2, 3, 4, 5, 6, 7, 8}, 4, 5};
    exp_ovf = '{11, 22, 33, 44};
    repeat (3) @(negedge clkin);
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_ovf", int'(overflow), 0);
    rst = 0;
    repeat (2) @(negedge clkin);
    avg_sel = 0;
    result = 700;
    adc_done = 1;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clkin);
      #1;
      n++;
    end
    check("latency", n, SYNC_STAGES + 3);
    check("lat_data", int'(out_data), 700);
    check("lat_count", int'(fifo_count), 1);
    repeat (10) @(negedge clkin);
    check("level_one_take", int'(fifo_count), 1);
    adc_done = 0;
    repeat (4) @(negedge clkin);
    pop1();
    for (int i = 0; i < 6; i++) begin
      avg_sel = 2'(tbl[i].sel);
      for (int k = 0; k < (1 << tbl[i].sel); k++) conv(tbl[i].s[k]);
      wait_valid($sformatf("vec%0d", i));
`ifdef ADC_AVG_ROUND_EN
      check($sformatf("vec%0d_data", i), int'(out_data), tbl[i].er);
`else
      check($sformatf("vec%0d_data", i), int'(out_data), tbl[i].et);
`endif
      check($sformatf("vec%0d_count", i), int'(fifo_count), 1);
      pop1();
      check($sformatf("vec%0d_empty", i), int'(out_valid), 0);
    end
    avg_sel = 0;
    out_ready = 0;
    for (int i = 0; i < 4; i++) conv(exp_ovf[i]);
    check("pre_ovf", int'(overflow), 0);
    conv(55);
    check("ovf_count", int'(fifo_count), 4);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_head", int'(out_data), 11);
    @(negedge clkin);
    clr_ovf = 1;
    @(negedge clkin);
    clr_ovf = 0;
    check("ovf_clr", int'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d", i), int'(out_data), exp_ovf[i]);
      pop1();
    end
    check("drain_count", int'(fifo_count), 0);
    avg_sel = 1;
    conv(200);
    @(negedge clkin);
    enable = 0;
    @(negedge clkin);
    enable = 1;
    conv(400);
    conv(600);
    wait_valid("abort");
    check("abort_data", int'(out_data), 500);
    check("abort_count", int'(fifo_count), 1);
    pop1();
    mon_en = 1;
    for (int b = 0; b < 30; b++) begin
      sel = $urandom_range(3);
      avg_sel = 2'(sel);
      sum = 0;
      for (int k = 0; k < (1 << sel); k++) begin
        ns = $urandom_range(1023);
        if (k == (1 << sel) - 1) rq.push_back(avg_of(sum + ns, sel));
        sum += ns;
        conv(ns);
        avg_sel = 2'($urandom_range(3));
      end
    end
    n = 0;
    while (rq.size() != 0 && n < 200) begin
      @(negedge clkin);
      n++;
    end
    check("rand_left", rq.size(), 0);
    mon_en = 0;
    @(negedge clkin);
    out_ready = 0;
    check("rand_ovf", int'(overflow), 0);
    avg_sel = 0;
    conv(1);
    conv(2);
    check("pre_rst_count", int'(fifo_count), 2);
    avg_sel = 2;
    conv(9);
    conv(9);
    @(negedge clkin);
    #2 rst = 1;
    #1;
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_count", int'(fifo_count), 0);
    @(negedge clkin);
    rst = 0;
    for (int k = 0; k < 4; k++) conv(50);
    wait_valid("post_rst");
    check("post_rst_data", int'(out_data), 50);
    check("post_rst_count", int'(fifo_count), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
